// File: rtl/tag_frame_assembler.sv
// Collects decoded tag bits after a preamble into a FRAME_BITS-wide frame (MSB first),
// optionally checks the Gen2 CRC-16 and offers the result over a valid/ready handshake.
module tag_frame_assembler #(
    parameter int FRAME_BITS = 16,
    parameter int CHECK_CRC  = 0,
    parameter int TIMEOUT    = 255,
    parameter int BANK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  preamble_detected,
    input  logic                  in_dat,
    input  logic                  in_vld,
    input  logic [BANK_WIDTH-1:0] in_bank,
    output logic [FRAME_BITS-1:0] frame_dat,
    output logic [BANK_WIDTH-1:0] frame_bank,
    output logic                  frame_crc_ok,
    output logic                  frame_vld,
    input  logic                  frame_rdy,
    output logic                  timeout_err,
    output logic [7:0]            drop_cnt
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                state, state_next;
    logic                  pre_q;
    logic                  start;
    logic [FRAME_BITS-1:0] shift_q, shift_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [15:0]           crc_q, crc_next;
    logic                  last_bit, to_expire;
    logic                  load, accept, done, abort, drop;

    assign start      = preamble_detected & ~pre_q;
    assign shift_next = {shift_q[FRAME_BITS-2:0], in_dat};
    assign crc_next   = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ in_dat) ? 16'h1021 : 16'h0000);
    assign last_bit   = (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign to_expire  = (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path leaves a value held (no latches).
    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                // A fresh preamble outranks everything, including the final bit of the frame.
                if (start) begin
                    load = 1'b1;
                end else if (in_vld) begin
                    accept = 1'b1;
                    if (last_bit) begin
                        done       = 1'b1;
                        state_next = HOLD;
                    end
                end else if (to_expire) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (frame_rdy) begin
                    load       = start;
                    state_next = start ? COLLECT : IDLE;
                end else if (start) begin
                    drop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the shift register is reset too, so a partial frame never survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= 1'b0;
            shift_q      <= '0;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            crc_q        <= 16'hFFFF;
            frame_dat    <= '0;
            frame_bank   <= '0;
            frame_crc_ok <= 1'b0;
            frame_vld    <= 1'b0;
            timeout_err  <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            pre_q       <= preamble_detected;
            timeout_err <= abort;
            if (load) begin
                bit_cnt    <= '0;
                to_cnt     <= '0;
                crc_q      <= 16'hFFFF;
                frame_bank <= in_bank;
            end else if (accept) begin
                shift_q <= shift_next;
                crc_q   <= crc_next;
                bit_cnt <= bit_cnt + 1'b1;
                to_cnt  <= '0;
            end else if (state == COLLECT && to_cnt != TO_W'(TIMEOUT)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (done) begin
                frame_dat    <= shift_next;
                frame_crc_ok <= (CHECK_CRC != 0) ? (crc_next == 16'h1D0F) : 1'b1;
                frame_vld    <= 1'b1;
            end else if (state == HOLD && frame_rdy) begin
                frame_vld <= 1'b0;
            end

            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: doc/tag_frame_assembler.md
Name: tag_frame_assembler

Overview:
- Sits directly downstream of preamble_detector.
- Once a preamble is detected, it collects the decoded tag bits (out_dat/out_vld) into a fixed-length frame, MSB first.
- Optionally checks the EPC Gen2 CRC-16 and tags the frame with the frequency bank that locked.
- Presents the completed frame to the reader controller over a valid/ready handshake; handles truncated replies (timeout) and back-pressure (drop counting).

Parameters:
- FRAME_BITS, 16, bits per frame including CRC when checked (16 = RN16; 128 = typical PC+EPC+CRC).
- CHECK_CRC, 0, 1 = run CRC-16 over all FRAME_BITS bits; 0 = crc_ok tied to 1.
- TIMEOUT, 255, max clk cycles between accepted bits (or from frame start to first bit) before abort; >=1.
- BANK_WIDTH, 4, width of frequency bank index (= $clog2(BANKS) of the detector).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- preamble_detected  in  1  from detector; the block edge-detects internally, so a pulse or a level both work.
- in_dat  in  1  decoded bit (detector out_dat).
- in_vld  in  1  in_dat qualifier (detector out_vld).
- in_bank  in  BANK_WIDTH  detector frequency_bank.
- frame_dat  out  FRAME_BITS  assembled frame; first received bit is in the MSB.
- frame_bank  out  BANK_WIDTH  in_bank sampled on the preamble rising edge.
- frame_crc_ok  out  1  CRC residue correct (1 when CHECK_CRC=0).
- frame_vld  out  1  frame available.
- frame_rdy  in  1  consumer accepts.
- timeout_err  out  1  one-cycle pulse on abort.
- drop_cnt  out  8  saturating count of preambles ignored while a frame was held.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - frame_dat=0, frame_bank=0, frame_crc_ok=0, frame_vld=0, timeout_err=0, drop_cnt=0.
  - Bit counter=0, timeout counter=0, CRC register=16'hFFFF.
  - Preamble edge register is cleared to 0, so a level-high preamble_detected at release counts as a rising edge.
  - Reset takes effect immediately, mid-frame included; any partial frame is discarded.
- Start event: preamble_detected=1 while its registered copy was 0.
- State IDLE:
  - On a start event: go to COLLECT.
  - Clear the bit counter and timeout counter, preset CRC to FFFF, latch in_bank into frame_bank.
  - An in_vld in the start cycle is NOT taken as a frame bit.
- State COLLECT, bit acceptance:
  - Each cycle with in_vld=1 shifts in_dat into the LSB of the shift register (left shift).
  - The same cycle updates the CRC serially: poly 0x1021, MSB-first; feedback = crc[15]^in_dat.
  - The same cycle increments the bit counter and clears the timeout counter.
- State COLLECT, frame complete:
  - When the FRAME_BITS-th bit is accepted, go to HOLD on the next edge.
  - On that edge: frame_dat = full shift register; frame_crc_ok = (next CRC == 16'h1D0F) when CHECK_CRC=1, else 1; frame_vld=1.
  - Latency from the last in_vld to frame_vld: 1 cycle.
- State COLLECT, timeout:
  - Each cycle without in_vld increments the timeout counter.
  - When the counter reaches TIMEOUT (i.e. after TIMEOUT consecutive idle cycles), go to IDLE and pulse timeout_err for 1 cycle.
  - frame_vld stays 0.
- State COLLECT, new start event: restart the frame (same actions as IDLE→COLLECT) and discard the partial bits.
  - If the start event and the final bit coincide, the restart wins.
- State HOLD:
  - frame_vld held at 1; frame_dat, frame_bank and frame_crc_ok are stable.
  - frame_vld & frame_rdy: frame_vld drops next cycle and state goes to IDLE.
  - A start event in the same cycle as the handshake goes directly to COLLECT (back-to-back frames, no lost bits).
  - A start event in HOLD without the handshake is ignored; drop_cnt increments, saturating at 255. in_vld is also ignored.
- frame_rdy is don't-care while frame_vld=0.
- Bit counter width = $clog2(FRAME_BITS+1). Timeout counter width = $clog2(TIMEOUT+1); it saturates and does not wrap.

Test Plan:
- Reset mid-COLLECT: after 7 of 16 bits, drive rst_n=0 → all outputs 0 immediately. After release, a full frame 16'hBEEF assembles correctly.
- RN16 basic: FRAME_BITS=16, CHECK_CRC=0, in_bank=5. Pulse preamble, then send bits of 16'hA5C3 MSB first with random in_vld gaps <100 cycles, frame_rdy=1. → frame_vld rises 1 cycle after the 16th bit; frame_dat=16'hA5C3, frame_bank=5, frame_crc_ok=1, frame_vld is a one-cycle pulse.
- CRC: CHECK_CRC=1, FRAME_BITS=32. Send 16'h3000 followed by its Gen2 CRC (ones' complement of CRC-16, preset FFFF, computed by the bench model). → frame_crc_ok=1. Repeat with bit 0 flipped → frame_crc_ok=0; frame_dat still equals the bits sent.
- Timeout: TIMEOUT=20. Send 9 bits, then in_vld=0 → timeout_err pulses exactly 20 cycles after the 9th bit; no frame_vld. The next preamble gives a clean frame.
- Back-pressure: frame_rdy=0 with a frame held; pulse preamble 3 times → drop_cnt=3, frame_dat unchanged. Raise frame_rdy together with a 4th preamble → frame accepted and the next 16 bits form the new frame.
- Restart: send 10 bits, re-pulse preamble, then send 16'h1234 → frame_dat=16'h1234; the partial bits are not visible.
